sr_latch_ctrl: RTL and testbench

Sequencer and arbiter for a bank of NUM_LATCH cross-coupled NOR SR latches.
- Accepts set/clear/toggle commands from two requesters and grants them round-robin.
- Drives each latch's S/R inputs with timed pulses, then a quiet gap, then checks latch Q feedback.
- Guarantees the forbidden S=R=1 input combination never occurs on any latch.
- Sits between the bus-side command logic and the latch bank.

---
 rtl/sr_latch_ctrl_pkg.sv | 19 +
 rtl/sr_latch_ctrl_rr_arb2.sv | 20 ++
 rtl/sr_latch_ctrl.sv | 158 +++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_ctrl_pkg.sv
// Shared definitions for the SR latch sequencer: op codes, FSM states and
// the pulse/gap counter width helper.
package sr_ctrl_pkg;

  localparam logic [1:0] OP_SET = 2'd0;
  localparam logic [1:0] OP_CLR = 2'd1;
  localparam logic [1:0] OP_TGL = 2'd2;
  localparam logic [1:0] OP_NOP = 2'd3;

  typedef enum logic [2:0] {IDLE, PULSE, GAP, CHECK, INIT} state_t;

  // Wide enough to hold max(p, g) itself, since the INIT phase counts up to p.
  function automatic int cnt_w(input int p, input int g);
    int m;
    m = (p > g) ? p : g;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sr_latch_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic prio1;

  assign grant[0] = valid[0] & (~valid[1] | ~prio1);
  assign grant[1] = valid[1] & (~valid[0] | prio1);

  always_ff @(posedge clock) begin
    if (reset)                 prio1 <= 1'b0;
    else if (accept && |grant) prio1 <= grant[0];
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer/arbiter driving a bank of NOR SR latches with timed S/R pulses.
// Optional SR_LATCH_CTRL_INIT_CLEAR_EN adds a clear-all INIT phase after reset.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int NUM_LATCH    = 4,
  parameter int IDXW         = 2,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [IDXW-1:0]      req0_idx,
  input  logic [1:0]           req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [IDXW-1:0]      req1_idx,
  input  logic [1:0]           req1_op,
  output logic [NUM_LATCH-1:0] latch_s,
  output logic [NUM_LATCH-1:0] latch_r,
  input  logic [NUM_LATCH-1:0] latch_q,
  output logic                 busy,
  output logic                 done,
  output logic                 done_src,
  output logic                 err,
  output logic [IDXW-1:0]      err_idx
);

  localparam int CW = cnt_w(PULSE_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [IDXW:0] N_LIM  = (IDXW + 1)'(NUM_LATCH);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   src;
  logic [IDXW-1:0]        idx_r;
  logic [NUM_LATCH-1:0]   mask_r;
  logic                   want_set;
  logic                   skip;
`ifdef SR_LATCH_CTRL_INIT_CLEAR_EN
  localparam logic [CW-1:0] P_FULL = CW'(PULSE_CYCLES);
  logic                   init_r;
`endif

  logic [1:0]             grant;
  logic                   idle;
  logic [IDXW-1:0]        sel_idx;
  logic [1:0]             sel_op;
  logic [NUM_LATCH-1:0]   sel_mask;
  logic                   sel_skip;
  logic                   sel_set;
  logic                   q_hit;

  assign idle = (state == IDLE);
  assign busy = ~idle;

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .valid  ({req1_valid, req0_valid}),
    .accept (idle),
    .grant  (grant)
  );

  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];

  // An out-of-range index shifts the single bit off the end, giving an empty mask.
  assign sel_idx  = grant[1] ? req1_idx : req0_idx;
  assign sel_op   = grant[1] ? req1_op  : req0_op;
  assign sel_mask = NUM_LATCH'(1) << sel_idx;
  assign sel_skip = (sel_op == OP_NOP) || ({1'b0, sel_idx} >= N_LIM);
  assign sel_set  = (sel_op == OP_SET) || ((sel_op == OP_TGL) && !(|(latch_q & sel_mask)));
  assign q_hit    = |(latch_q & mask_r);

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef SR_LATCH_CTRL_INIT_CLEAR_EN
      state  <= INIT;
      init_r <= 1'b1;
`else
      state  <= IDLE;
`endif
      cnt      <= '0;
      src      <= 1'b0;
      idx_r    <= '0;
      mask_r   <= '0;
      want_set <= 1'b0;
      skip     <= 1'b0;
      latch_s  <= '0;
      latch_r  <= '0;
      done     <= 1'b0;
      done_src <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (|grant) begin
          src      <= grant[1];
          idx_r    <= sel_idx;
          mask_r   <= sel_mask;
          want_set <= sel_set;
          skip     <= sel_skip;
          cnt      <= '0;
          if (sel_skip) state <= CHECK;
          else begin
            state <= PULSE;
            if (sel_set) latch_s <= sel_mask;
            else         latch_r <= sel_mask;
          end
        end
        PULSE: if (cnt == P_LAST) begin
          latch_s <= '0;
          latch_r <= '0;
          cnt     <= '0;
          state   <= GAP;
        end else cnt <= cnt + CW'(1);
        GAP: if (cnt == G_LAST) begin
          cnt <= '0;
`ifdef SR_LATCH_CTRL_INIT_CLEAR_EN
          if (init_r) begin
            init_r <= 1'b0;
            state  <= IDLE;
          end else state <= CHECK;
`else
          state <= CHECK;
`endif
        end else cnt <= cnt + CW'(1);
        CHECK: begin
          done     <= 1'b1;
          done_src <= src;
          // Only the first mismatch is recorded; err is sticky until reset.
          if (!skip && (q_hit != want_set) && !err) begin
            err     <= 1'b1;
            err_idx <= idx_r;
          end
          state <= IDLE;
        end
`ifdef SR_LATCH_CTRL_INIT_CLEAR_EN
        INIT: if (cnt == P_FULL) begin
          latch_r <= '0;
          cnt     <= '0;
          state   <= GAP;
        end else begin
          latch_r <= '1;
          cnt     <= cnt + CW'(1);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench for sr_latch_ctrl: cycle-timeline reference model plus
// directed literal checks and a long randomized run with a latch-bank model.
module tb_sr_latch_ctrl;

  localparam int NL = 4;
  localparam int IW = 3;
  localparam int P  = 2;
  localparam int G  = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [IW-1:0] i0 = '0, i1 = '0;
  logic [1:0] o0 = 2'd3, o1 = 2'd3;
  logic req0_ready, req1_ready, busy, done, done_src, err;
  logic [NL-1:0] latch_s, latch_r, latch_q;
  logic [IW-1:0] err_idx;
  logic [NL-1:0] lq = '0, stuck = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sr_latch_ctrl #(.NUM_LATCH(NL), .IDXW(IW), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_idx(i0), .req0_op(o0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_idx(i1), .req1_op(o1),
    .latch_s(latch_s), .latch_r(latch_r), .latch_q(latch_q),
    .busy(busy), .done(done), .done_src(done_src), .err(err), .err_idx(err_idx)
  );

  // Physical latch bank: S sets, R clears, stuck bits read back as 0.
  assign latch_q = lq & ~stuck;
  always @(posedge clock)
    for (int i = 0; i < NL; i++)
      if (latch_s[i])      lq[i] <= 1'b1;
      else if (latch_r[i]) lq[i] <= 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted command becomes a timeline of absolute cycles.
  int cyc = 0, free_at = 0, ps = -1000, chk_at = -1000, done_at = -1000, init_st = -1000;
  logic [NL-1:0] pmask = '0;
  logic pset = 1'b0, want_m = 1'b0, skip_m = 1'b0, dsrc_m = 1'b0, lg = 1'b1, err_m = 1'b0;
  logic [IW-1:0] idx_m = '0, eidx_m = '0;
  bit armed = 1'b0;

  always @(negedge clock) begin : cmp
    logic eb, er0, er1, s;
    logic [NL-1:0] es, erv;
    logic [IW-1:0] ix;
    logic [1:0] op;
    eb  = cyc < free_at;
    er0 = !eb && v0 && (!v1 || lg);
    er1 = !eb && v1 && (!v0 || !lg);
    es  = (cyc >= ps && cyc < ps + P &&  pset) ? pmask : '0;
    erv = (cyc >= ps && cyc < ps + P && !pset) ? pmask : '0;
    if (cyc >= init_st && cyc < init_st + P) erv = '1;
    if (armed) begin
      check("busy", busy, eb);
      check("req0_ready", req0_ready, er0);
      check("req1_ready", req1_ready, er1);
      check("latch_s", latch_s, es);
      check("latch_r", latch_r, erv);
      check("done", done, cyc == done_at);
      if (cyc == done_at) check("done_src", done_src, dsrc_m);
      check("err", err, err_m);
      check("err_idx", err_idx, eidx_m);
      check("sr_overlap", latch_s & latch_r, 0);
      if (!(cyc >= init_st && cyc < init_st + P))
        check("sr_onehot", $countones(latch_s | latch_r) <= 1, 1);
    end
    if (reset) begin
      free_at = cyc + 1; ps = -1000; chk_at = -1000; done_at = -1000;
      lg = 1'b1; err_m = 1'b0; eidx_m = '0; dsrc_m = 1'b0;
`ifdef SR_LATCH_CTRL_INIT_CLEAR_EN
      init_st = cyc + 2; free_at = cyc + 2 + P + G;
`endif
      armed = 1'b1;
    end else begin
      if (cyc == chk_at && !skip_m && (latch_q[idx_m[1:0]] != want_m) && !err_m) begin
        err_m = 1'b1; eidx_m = idx_m;
      end
      if (er0 || er1) begin
        s  = er1;
        ix = s ? i1 : i0;
        op = s ? o1 : o0;
        idx_m  = ix;
        dsrc_m = s;
        lg     = s;
        skip_m = (op == 2'd3) || (ix >= IW'(NL));
        want_m = (op == 2'd0) || (op == 2'd2 && !latch_q[ix[1:0]]);
        if (skip_m) chk_at = cyc + 1;
        else begin
          ps = cyc + 1; pmask = NL'(1) << ix; pset = want_m;
          chk_at = cyc + P + G + 1;
        end
        done_at = chk_at + 1;
        free_at = chk_at + 1;
      end
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic send(input int s, input int idx, input logic [1:0] op);
    bit ok;
    tick;
    if (s == 0) begin v0 = 1'b1; i0 = IW'(idx); o0 = op; end
    else        begin v1 = 1'b1; i1 = IW'(idx); o1 = op; end
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clock);
      if ((s == 0) ? req0_ready : req1_ready) ok = 1'b1;
    end
    tick;
    v0 = 1'b0; v1 = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: req%0d never ready, expected within 50 cycles", s);
    end
  endtask

  task automatic wait_idle;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clock);
      if (!busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy stuck at 1, expected 0 within 30 cycles");
    end
  endtask

  task automatic pair(input logic [1:0] op0, input int ix0, input logic [1:0] op1, input int ix1,
                      output int first, output int second);
    int got;
    logic r0, r1;
    got = 0; first = -1; second = -1;
    tick;
    v0 = 1'b1; o0 = op0; i0 = IW'(ix0);
    v1 = 1'b1; o1 = op1; i1 = IW'(ix1);
    for (int k = 0; k < 60 && got < 2; k++) begin
      @(negedge clock);
      r0 = req0_ready; r1 = req1_ready;
      tick;
      if (r0 || r1) begin
        if (got == 0) first = int'(r1); else second = int'(r1);
        got++;
        if (r1) v1 = 1'b0; else v0 = 1'b0;
      end
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  int f, sc;

  initial begin
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;

    // Set idx2: S pulse 2 cycles, gap 1, done 4 cycles after the accept edge.
    send(0, 2, 2'd0);
    @(negedge clock); check("t1_s_c1", latch_s, 4'b0100); check("t1_busy", busy, 1);
    @(negedge clock); check("t1_s_c2", latch_s, 4'b0100);
    @(negedge clock); check("t1_s_gap", latch_s, 4'b0000); check("t1_r_gap", latch_r, 4'b0000);
    @(negedge clock); check("t1_done_early", done, 0);
    @(negedge clock); check("t1_done", done, 1); check("t1_src", done_src, 0); check("t1_err", err, 0);

    // Arbitration from a fresh pointer, then after req0 was granted last.
    tick; reset = 1'b1; tick; reset = 1'b0;
    pair(2'd1, 1, 2'd0, 3, f, sc);
    check("t2_first", f, 0); check("t2_second", sc, 1);
    wait_idle;
    send(0, 0, 2'd0);
    wait_idle;
    pair(2'd0, 1, 2'd0, 2, f, sc);
    check("t2b_first", f, 1); check("t2b_second", sc, 0);
    wait_idle;

    // Toggle resolves from the Q sampled at accept.
    send(0, 0, 2'd0); wait_idle;
    send(0, 0, 2'd2);
    @(negedge clock); check("t3_tgl1_r", latch_r, 4'b0001); check("t3_tgl1_s", latch_s, 4'b0000);
    wait_idle; check("t3_err1", err, 0);
    send(0, 0, 2'd2);
    @(negedge clock); check("t3_tgl0_s", latch_s, 4'b0001); check("t3_tgl0_r", latch_r, 4'b0000);
    wait_idle; check("t3_err0", err, 0);

    // Stuck-at-0 latches: the first mismatch index is kept.
    tick; stuck = 4'b1000;
    send(1, 3, 2'd0); wait_idle;
    check("t4_err", err, 1); check("t4_err_idx", err_idx, 3);
    tick; stuck = 4'b1010;
    send(0, 1, 2'd0); wait_idle;
    check("t4_err_keep", err, 1); check("t4_err_idx_keep", err_idx, 3);

    // Reset during the second pulse cycle drops S/R immediately.
    tick; stuck = 4'b0000;
    send(0, 2, 2'd0);
    tick; reset = 1'b1;
    tick; reset = 1'b0;
    @(negedge clock);
    check("t5_s", latch_s, 4'b0000); check("t5_r", latch_r, 4'b0000); check("t5_err", err, 0);
`ifdef SR_LATCH_CTRL_INIT_CLEAR_EN
    check("t5_busy", busy, 1);
`else
    check("t5_busy", busy, 0);
`endif

    // nop and out-of-range index: no pulse, done right after CHECK.
    send(0, 0, 2'd3);
    @(negedge clock); check("t6_nop_sr", latch_s | latch_r, 4'b0000); check("t6_nop_done0", done, 0);
    @(negedge clock); check("t6_nop_done", done, 1);
    send(1, 5, 2'd0);
    @(negedge clock); check("t6_oor_sr", latch_s | latch_r, 4'b0000); check("t6_oor_done0", done, 0);
    @(negedge clock); check("t6_oor_done", done, 1); check("t6_oor_src", done_src, 1);

    // Random traffic with occasional stuck bits and resets.
    for (int n = 0; n < 40000; n++) begin
      tick;
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 6);
      i0 = IW'($urandom_range(0, 7)); i1 = IW'($urandom_range(0, 7));
      o0 = 2'($urandom_range(0, 3));  o1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) stuck = NL'($urandom_range(0, 15)) & NL'($urandom_range(0, 15));
      reset = ($urandom_range(0, 999) == 0);
    end
    tick; v0 = 1'b0; v1 = 1'b0; reset = 1'b0;
    repeat (10) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
